// File: rtl/wr_txn_issuer.sv
// Single-beat AXI-style write issuer: accepts one request, drives AW and W
// independently, waits for B, then pulses done, err or timeout back to the requester.
module wr_txn_issuer #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ADDR_WIDTH-1:0]   s_addr,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_strb,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    done,
  output logic                    err,
  output logic                    timeout,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic                   aw_done, aw_done_n;
  logic                   w_done, w_done_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic                   done_n, err_n, timeout_n;
  logic                   load;
  logic                   aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [STRB_WIDTH-1:0]  strb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      cnt     <= cnt_n;
      done    <= done_n;
      err     <= err_n;
      timeout <= timeout_n;
      if (load) begin
        addr_q <= s_addr;
        data_q <= s_data;
        strb_q <= s_strb;
      end
    end
  end

  // The done flags stay set through RESP and are cleared together with the
  // counter on the way back to IDLE.
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    cnt_n     = cnt;
    done_n    = 1'b0;
    err_n     = 1'b0;
    timeout_n = 1'b0;
    load      = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          load    = 1'b1;
          state_n = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        aw_hs     = !aw_done && m_awready;
        w_hs      = !w_done && m_wready;
        aw_done_n = aw_done || aw_hs;
        w_done_n  = w_done || w_hs;
        if (aw_done_n && w_done_n) begin
          state_n = RESP;
        end
      end
      RESP: begin
        // bvalid wins over a timeout expiring in the same cycle.
        if (m_bvalid) begin
          state_n   = IDLE;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          cnt_n     = '0;
          done_n    = (m_bresp == 2'b00);
          err_n     = (m_bresp != 2'b00);
        end else if ((TIMEOUT_CYCLES > 0) && (cnt == CNT_WIDTH'(CNT_LAST))) begin
          state_n   = IDLE;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          cnt_n     = '0;
          timeout_n = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        cnt_n     = '0;
      end
    endcase
  end

  assign s_ready   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign m_awvalid = (state == ADDR_DATA) && !aw_done;
  assign m_wvalid  = (state == ADDR_DATA) && !w_done;
  assign m_bready  = (state == RESP);
  assign m_awaddr  = addr_q;
  assign m_wdata   = data_q;
  assign m_wstrb   = strb_q;

endmodule
